mem_port_arbiter: RTL and testbench

Arbiter that shares the single-port instruction/data memory between the fetch stage and the data-memory (load/store) stage. Each cycle it grants at most one requester, drives the memory interface, and returns read data one cycle later tagged to the winning requester. It asserts `intrlock_bubble` whenever fetch is denied, so the fetcher holds `pc`. An anti-starvation counter guarantees fetch progress under continuous load/store traffic.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data-memory and memory-macro signals around the shared-port arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ex_branch_flush;
    logic        intrlock_bubble;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_in;
    logic [31:0] mem_dat_out;

    modport slave (
        input  if_req, if_addr, ex_branch_flush,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_dat_out,
        output if_gnt, if_rvalid, if_rdata, intrlock_bubble,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_dat_in
    );

    modport master (
        output if_req, if_addr, ex_branch_flush,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_dat_out,
        input  if_gnt, if_rvalid, if_rdata, intrlock_bubble,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_dat_in
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store; data has priority,
// with a starvation counter that forces a fetch win after STARVE_MAX lost contended cycles.
//
// rsp_q state | meaning
// ------------+------------------------------------------------
// RSP_NONE    | no read data returning this cycle
// RSP_IF      | mem_dat_out carries the instruction for fetch
// RSP_DM      | mem_dat_out carries load data for the data port
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    rsp_t        rsp_q;
    rsp_t        rsp_d;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_cnt_d;
    logic        fetch_win;
    logic        if_gnt;
    logic        dm_gnt;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q      <= RSP_NONE;
            starve_cnt <= '0;
        end else begin
            rsp_q      <= rsp_d;
            starve_cnt <= starve_cnt_d;
        end
    end

    always_comb begin
        // A flush only suppresses the fetch grant; it does not hand the slot to data.
        fetch_win = bus.if_req & (~bus.dm_req | (starve_cnt == STARVE_LIM));
        if_gnt    = fetch_win & ~bus.ex_branch_flush;
        dm_gnt    = bus.dm_req & ~fetch_win;

        rsp_d = RSP_NONE;
        if (if_gnt) begin
            rsp_d = RSP_IF;
        end else if (dm_gnt && !bus.dm_we) begin
            rsp_d = RSP_DM;
        end

        starve_cnt_d = starve_cnt;
        if (if_gnt || !bus.if_req || bus.ex_branch_flush) begin
            starve_cnt_d = '0;
        end else if (dm_gnt && (starve_cnt < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt + 4'd1;
        end

        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'h0;
        mem_addr   = 32'h0;
        mem_dat_in = 32'h0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = bus.if_addr;
        end else if (dm_gnt) begin
            mem_en     = 1'b1;
            mem_we     = bus.dm_we;
            mem_be     = bus.dm_be;
            mem_addr   = bus.dm_addr;
            mem_dat_in = bus.dm_wdata;
        end
    end

    // Reset in the response cycle discards the returning read.
    assign bus.if_rvalid       = (rsp_q == RSP_IF) & ~bus.ex_branch_flush & ~rst;
    assign bus.dm_rvalid       = (rsp_q == RSP_DM) & ~rst;
    assign bus.if_rdata        = bus.mem_dat_out;
    assign bus.dm_rdata        = bus.mem_dat_out;
    assign bus.if_gnt          = if_gnt;
    assign bus.dm_gnt          = dm_gnt;
    assign bus.intrlock_bubble = bus.if_req & ~if_gnt;
    assign bus.mem_en          = mem_en;
    assign bus.mem_we          = mem_we;
    assign bus.mem_be          = mem_be;
    assign bus.mem_addr        = mem_addr;
    assign bus.mem_dat_in      = mem_dat_in;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a cycle-level behavioural model
// with its own memory array.
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 3;

    logic clk;
    logic rst;
    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // stimulus for the next cycle
    logic        nx_rst, nx_if_req, nx_flush, nx_dm_req, nx_dm_we;
    logic [31:0] nx_if_addr, nx_dm_addr, nx_dm_wdata;
    logic [3:0]  nx_dm_be;

    // memory model and returning read data
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_next;

    // reference model state
    int          m_losses;   // consecutive contended cycles fetch has lost
    int          m_owner;    // 0 none, 1 fetch, 2 data
    logic [31:0] m_data;
    bit          started;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], 16'hA5C3};
    endfunction

    task automatic set_idle();
        nx_rst = 0; nx_if_req = 0; nx_flush = 0; nx_dm_req = 0; nx_dm_we = 0;
        nx_if_addr = 0; nx_dm_addr = 0; nx_dm_wdata = 0; nx_dm_be = 0;
    endtask

    task automatic step();
        bit          fetch_wins, e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv;
        logic [31:0] e_addr, wr;
        @(posedge clk);
        #1;
        rst                 = nx_rst;
        bus.if_req          = nx_if_req;
        bus.if_addr         = nx_if_addr;
        bus.ex_branch_flush = nx_flush;
        bus.dm_req          = nx_dm_req;
        bus.dm_we           = nx_dm_we;
        bus.dm_be           = nx_dm_be;
        bus.dm_addr         = nx_dm_addr;
        bus.dm_wdata        = nx_dm_wdata;
        bus.mem_dat_out     = rd_next;
        @(negedge clk);

        fetch_wins = nx_if_req && (!nx_dm_req || m_losses == STARVE_MAX);
        e_if_gnt   = fetch_wins && !nx_flush;
        e_dm_gnt   = nx_dm_req && !fetch_wins;
        e_if_rv    = !nx_rst && m_owner == 1 && !nx_flush;
        e_dm_rv    = !nx_rst && m_owner == 2;
        e_addr     = e_if_gnt ? nx_if_addr : (e_dm_gnt ? nx_dm_addr : 32'h0);

        if (started) begin
            chk("if_gnt", 32'(bus.if_gnt), 32'(e_if_gnt));
            chk("dm_gnt", 32'(bus.dm_gnt), 32'(e_dm_gnt));
            chk("bubble", 32'(bus.intrlock_bubble), 32'(nx_if_req && !e_if_gnt));
            chk("mem_en", 32'(bus.mem_en), 32'(e_if_gnt || e_dm_gnt));
            chk("mem_we", 32'(bus.mem_we), 32'(e_dm_gnt && nx_dm_we));
            chk("mem_be", 32'(bus.mem_be), e_if_gnt ? 32'hF : (e_dm_gnt ? 32'(nx_dm_be) : 32'h0));
            chk("mem_addr", bus.mem_addr, e_addr);
            if (!e_if_gnt) chk("mem_dat_in", bus.mem_dat_in, e_dm_gnt ? nx_dm_wdata : 32'h0);
        end
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_if_rv));
        chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(e_dm_rv));
        if (e_if_rv) chk("if_rdata", bus.if_rdata, m_data);
        if (e_dm_rv) chk("dm_rdata", bus.dm_rdata, m_data);

        // model advances to the next edge
        if (nx_rst) begin
            m_losses = 0;
            m_owner  = 0;
        end else begin
            if (e_if_gnt || !nx_if_req || nx_flush) m_losses = 0;
            else if (e_dm_gnt && m_losses < STARVE_MAX) m_losses++;
            m_owner = e_if_gnt ? 1 : ((e_dm_gnt && !nx_dm_we) ? 2 : 0);
            m_data  = mem_rd(e_addr);
        end

        // memory behaviour as seen from the DUT strobes
        rd_next = $urandom;
        if (bus.mem_en && !bus.mem_we) rd_next = mem_rd(bus.mem_addr);
        if (bus.mem_en && bus.mem_we) begin
            wr = mem_rd(bus.mem_addr);
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) wr[8*b +: 8] = bus.mem_dat_in[8*b +: 8];
            mem[bus.mem_addr] = wr;
        end
        started = 1;
    endtask

    initial begin
        started = 0; m_losses = 0; m_owner = 0; m_data = 0; rd_next = 0;
        mem[32'h100] = 32'h0000_0013;
        mem[32'h300] = 32'hCAFE_0000;
        set_idle();

        // reset with both requests high, then contention
        nx_rst = 1; nx_if_req = 1; nx_dm_req = 1; nx_if_addr = 32'h100; nx_dm_addr = 32'h300;
        step();
        step();
        nx_rst = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
                chk("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
            end
            chk("cont_dm_gnt", 32'(bus.dm_gnt), 32'((i % 4) != 3));
            chk("cont_if_gnt", 32'(bus.if_gnt), 32'((i % 4) == 3));
            chk("cont_bubble", 32'(bus.intrlock_bubble), 32'((i % 4) != 3));
        end
        set_idle();
        step();

        // fetch only
        nx_if_req = 1; nx_if_addr = 32'h100;
        step();
        chk("fo_if_gnt", 32'(bus.if_gnt), 32'h1);
        chk("fo_mem_addr", bus.mem_addr, 32'h100);
        chk("fo_bubble", 32'(bus.intrlock_bubble), 32'h0);
        set_idle();
        step();
        chk("fo_if_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("fo_if_rdata", bus.if_rdata, 32'h13);

        // data write
        nx_dm_req = 1; nx_dm_we = 1; nx_dm_be = 4'b0011; nx_dm_addr = 32'h200; nx_dm_wdata = 32'hDEADBEEF;
        step();
        chk("wr_mem_we", 32'(bus.mem_we), 32'h1);
        chk("wr_mem_be", 32'(bus.mem_be), 32'h3);
        chk("wr_dat_in", bus.mem_dat_in, 32'hDEADBEEF);
        set_idle();
        step();
        chk("wr_no_dm_rv", 32'(bus.dm_rvalid), 32'h0);
        chk("wr_no_if_rv", 32'(bus.if_rvalid), 32'h0);

        // fetch, then flush together with a new fetch request
        nx_if_req = 1; nx_if_addr = 32'h104;
        step();
        nx_flush = 1;
        step();
        chk("fl_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("fl_if_gnt", 32'(bus.if_gnt), 32'h0);
        chk("fl_mem_en", 32'(bus.mem_en), 32'h0);
        chk("fl_bubble", 32'(bus.intrlock_bubble), 32'h1);
        set_idle();

        // data read followed by fetch
        nx_dm_req = 1; nx_dm_addr = 32'h300;
        step();
        set_idle();
        nx_if_req = 1; nx_if_addr = 32'h100;
        step();
        chk("rd_dm_rvalid", 32'(bus.dm_rvalid), 32'h1);
        chk("rd_dm_rdata", bus.dm_rdata, 32'hCAFE0000);
        chk("rd_if_rvalid0", 32'(bus.if_rvalid), 32'h0);
        set_idle();
        step();
        chk("rd_if_rvalid1", 32'(bus.if_rvalid), 32'h1);

        // reset in the response cycle loses the read
        nx_dm_req = 1; nx_dm_addr = 32'h300;
        step();
        set_idle();
        nx_rst = 1;
        step();
        chk("rr_dm_rvalid0", 32'(bus.dm_rvalid), 32'h0);
        nx_rst = 0;
        step();
        chk("rr_dm_rvalid1", 32'(bus.dm_rvalid), 32'h0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            nx_rst      = ($urandom_range(0, 59) == 0);
            nx_if_req   = ($urandom_range(0, 9) < 7);
            nx_dm_req   = ($urandom_range(0, 9) < 7);
            nx_flush    = ($urandom_range(0, 7) == 0);
            nx_dm_we    = $urandom_range(0, 1);
            nx_dm_be    = 4'($urandom);
            nx_if_addr  = 32'h100 + 32'($urandom_range(0, 15) << 2);
            nx_dm_addr  = 32'h100 + 32'($urandom_range(0, 15) << 2);
            nx_dm_wdata = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
